// File: rtl/kyber_basemul.sv
// Kyber NTT-domain base multiplication: 32 beats x 8 lanes, pairs (2p, 2p+1).
// Three-stage pipeline: capture -> partial products -> Barrett-reduced result.
// The gamma table (zeta^(2*br7(i)+1) mod Q, zeta = 17) is built at elaboration
// by a constant function, so no ROM image file has to ship with the block.
// Optional: define BASEMUL_RANGE_CHECK_EN to flag accepted lanes >= Q on err.
module kyber_basemul #(
  parameter int unsigned Q      = 3329,
  parameter int unsigned NBEATS = 32,
  parameter int unsigned LAT    = 3     // must be >= 3; extra cycles are pure delay
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         valid_a,
  input  logic [127:0] data_a,
  input  logic         valid_b,
  input  logic [127:0] data_b,
  output logic         ready_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  output logic         done,
  output logic         err
);

  localparam int unsigned CntW     = $clog2(NBEATS + 1);
  localparam int unsigned Zeta     = 17;
  localparam int unsigned BarrettK = 26;
  localparam int unsigned BarrettM = (2 ** BarrettK) / Q;

  function automatic logic [1535:0] gen_gamma();
    logic [1535:0] rom;
    int unsigned   br, e, base, acc;
    rom = '0;
    for (int i = 0; i < 128; i++) begin
      br = 0;
      for (int b = 0; b < 7; b++) begin
        if (((i >> b) & 1) != 0) br = br | (32'd1 << (6 - b));
      end
      e    = 2 * br + 1;
      base = Zeta;
      acc  = 1;
      for (int b = 0; b < 8; b++) begin
        if (((e >> b) & 1) != 0) acc = (acc * base) % Q;
        base = (base * base) % Q;
      end
      rom[11'(i * 12) +: 12] = 12'(acc);
    end
    return rom;
  endfunction

  localparam logic [1535:0] GammaRom = gen_gamma();

  // Exact for x < 2^25: the quotient estimate is low by at most one.
  function automatic logic [11:0] barrett(input logic [24:0] x);
    logic [13:0] qe;
    logic [24:0] r;
    qe = 14'((40'(x) * 40'(BarrettM)) >> BarrettK);
    r  = x - 25'(qe) * 25'(Q);
    if (r >= 25'(Q)) r = r - 25'(Q);
    return 12'(r);
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic            accept;

  logic        v_s1_q, v_s2_q;
  logic [11:0] a_s1_q [8];
  logic [11:0] b_s1_q [8];
  logic [11:0] gam_d [4];
  logic [11:0] gam_s1_q [4];
  logic [11:0] gam_s2_q [4];
  logic [23:0] p00_d [4];
  logic [23:0] p00_q [4];
  logic [11:0] p11_d [4];
  logic [11:0] p11_q [4];
  logic [24:0] cross_d [4];
  logic [24:0] cross_q [4];
  logic [127:0] res_d;
  logic [127:0] res_q [LAT-2];
  logic [LAT-3:0] rv_q;

  assign ready_in  = (state_q == StRun) && (in_cnt_q < CntW'(NBEATS));
  assign accept    = valid_a && valid_b && ready_in;
  assign done      = (state_q == StDone);
  assign valid_out = rv_q[LAT-3];
  assign data_out  = res_q[LAT-3];

  // Next-state logic; out_cnt tracks beats already presented on valid_out.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = valid_out ? out_cnt_q + 1'b1 : out_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == CntW'(NBEATS - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (valid_out && (out_cnt_q == CntW'(NBEATS - 1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Gamma lookup for the four pairs of the beat being accepted.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      gam_d[p] = GammaRom[11'(48 * int'(in_cnt_q[CntW-2:0]) + 12 * p) +: 12];
    end
  end

  // Stage 1: capture accepted lanes and their gamma constants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s1_q <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        a_s1_q[j] <= '0;
        b_s1_q[j] <= '0;
      end
      for (int p = 0; p < 4; p++) gam_s1_q[p] <= '0;
    end else begin
      v_s1_q <= accept;
      if (accept) begin
        for (int j = 0; j < 8; j++) begin
          a_s1_q[j] <= data_a[7'(16 * j) +: 12];
          b_s1_q[j] <= data_b[7'(16 * j) +: 12];
        end
        for (int p = 0; p < 4; p++) gam_s1_q[p] <= gam_d[p];
      end
    end
  end

  // Partial products; a1*b1 is reduced here so the gamma multiply stays narrow.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      p00_d[p]   = 24'(a_s1_q[2*p]) * 24'(b_s1_q[2*p]);
      p11_d[p]   = barrett(25'(24'(a_s1_q[2*p+1]) * 24'(b_s1_q[2*p+1])));
      cross_d[p] = 25'(24'(a_s1_q[2*p]) * 24'(b_s1_q[2*p+1]))
                 + 25'(24'(a_s1_q[2*p+1]) * 24'(b_s1_q[2*p]));
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s2_q <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        p00_q[p]    <= '0;
        p11_q[p]    <= '0;
        cross_q[p]  <= '0;
        gam_s2_q[p] <= '0;
      end
    end else begin
      v_s2_q <= v_s1_q;
      if (v_s1_q) begin
        for (int p = 0; p < 4; p++) begin
          p00_q[p]    <= p00_d[p];
          p11_q[p]    <= p11_d[p];
          cross_q[p]  <= cross_d[p];
          gam_s2_q[p] <= gam_s1_q[p];
        end
      end
    end
  end

  // Final reduction and repacking into 16-bit zero-extended lanes.
  always_comb begin
    res_d = '0;
    for (int p = 0; p < 4; p++) begin
      res_d[7'(32 * p) +: 12]      = barrett(25'(p00_q[p]) + 25'(24'(p11_q[p]) * 24'(gam_s2_q[p])));
      res_d[7'(32 * p + 16) +: 12] = barrett(cross_q[p]);
    end
  end

  // Output register plus optional extra delay up to LAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q <= '0;
      for (int i = 0; i < LAT - 2; i++) res_q[i] <= '0;
    end else begin
      rv_q[0] <= v_s2_q;
      if (v_s2_q) res_q[0] <= res_d;
      for (int i = 1; i < LAT - 2; i++) begin
        rv_q[i] <= rv_q[i-1];
        if (rv_q[i-1]) res_q[i] <= res_q[i-1];
      end
    end
  end

`ifdef BASEMUL_RANGE_CHECK_EN
  logic err_q;
  logic bad_lane;

  // Any lane (including its upper nibble) at or above Q is out of range.
  always_comb begin
    bad_lane = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (data_a[7'(16 * j) +: 16] >= 16'(Q) || data_b[7'(16 * j) +: 16] >= 16'(Q)) begin
        bad_lane = 1'b1;
      end
    end
  end

  // Sticky error, cleared when a new polynomial starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      err_q <= 1'b0;
    end else if (accept && bad_lane) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic [63:0] unused_hi;

  // Upper lane nibbles only matter to the range check.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      unused_hi[6'(8 * j) +: 4]     = data_a[7'(16 * j + 12) +: 4];
      unused_hi[6'(8 * j + 4) +: 4] = data_b[7'(16 * j + 12) +: 4];
    end
  end

  assign err = 1'b0;
`endif

endmodule
